// File: rtl/hpdcache_flush_walker_pkg.sv
// -----------------------------------------------------------------------------
// hpdcache_flush_walker_pkg
//   Shared types and helpers for the flush walker.
//   - hpdcache_cfg_t          : cache geometry (sets, ways, banks, set width)
//   - hpdcache_at_least_one   : clamps a geometry count so a zero default
//                               configuration still yields legal ranges
//   - hpdcache_prio_1hot      : lowest-set-bit priority encoder (one-hot out)
//   - hpdcache_1hot_to_binary : one-hot to binary index
// -----------------------------------------------------------------------------
package hpdcache_flush_walker_pkg;

  typedef struct packed {
    int unsigned nSets;
    int unsigned nWays;
    int unsigned nBanks;
    int unsigned setWidth;
  } hpdcache_cfg_t;

  function automatic int unsigned hpdcache_at_least_one(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  // Two's-complement trick: v & -v isolates the lowest set bit.
  function automatic logic [31:0] hpdcache_prio_1hot(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

  function automatic logic [4:0] hpdcache_1hot_to_binary(input logic [31:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hpdcache_flush_walker.sv
// -----------------------------------------------------------------------------
// hpdcache_flush_walker
//   Walks every set of the cache directory on a flush-all command, hands each
//   dirty line to the flush controller, clears its dirty bit as the request is
//   accepted, then waits for outstanding writebacks to drain.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i / start_ready_o       flush-all command handshake
//   busy_o, done_o                walk in progress, one-cycle completion pulse
//   dir_read_o/_gnt_i/_set_o      directory read request
//   dir_dirty_i, dir_tag_i        directory response, valid one cycle after grant
//   dir_clean_o/_set_o/_way_o     dirty-bit clear, pulsed on each accepted alloc
//   flush_alloc_o/_ready_i/...    writeback request to the flush controller
//   flush_empty_i                 flush controller holds no writebacks
//   dbg_state_o                   current walker state for observation
//
// Handshakes: a request (start, dir_read, flush_alloc) transfers on a rising
// edge where both its valid and ready/grant are high; a raised valid is held
// with a stable payload until that transfer, and is never withdrawn early.
// -----------------------------------------------------------------------------
module hpdcache_flush_walker
  import hpdcache_flush_walker_pkg::*;
#(
  parameter hpdcache_cfg_t HPDcacheCfg = '0,
  parameter type hpdcache_set_t         = logic,
  parameter type hpdcache_tag_t         = logic,
  parameter type hpdcache_nline_t       = logic,
  parameter type hpdcache_way_vector_t  = logic,
  parameter type hpdcache_bank_id_t     = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 start_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 dir_read_o,
  input  logic                 dir_read_gnt_i,
  output hpdcache_set_t        dir_read_set_o,
  input  hpdcache_way_vector_t dir_dirty_i,
  input  hpdcache_tag_t [hpdcache_at_least_one(HPDcacheCfg.nWays)-1:0] dir_tag_i,
  output logic                 dir_clean_o,
  output hpdcache_set_t        dir_clean_set_o,
  output hpdcache_way_vector_t dir_clean_way_o,
  output logic                 flush_alloc_o,
  input  logic                 flush_alloc_ready_i,
  output hpdcache_nline_t      flush_alloc_nline_o,
  output hpdcache_way_vector_t flush_alloc_way_o,
  output hpdcache_bank_id_t    flush_alloc_bank_id_o,
  input  logic                 flush_empty_i,
  output logic [2:0]           dbg_state_o
);

  localparam int unsigned NWAYS = hpdcache_at_least_one(HPDcacheCfg.nWays);
  localparam int unsigned WAY_W = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam hpdcache_set_t LAST_SET = hpdcache_set_t'(HPDcacheCfg.nSets - 1);
  // Banks are interleaved on the low set bits; a single bank masks to zero.
  localparam hpdcache_set_t BANK_MASK =
    hpdcache_set_t'((HPDcacheCfg.nBanks > 1) ? (HPDcacheCfg.nBanks - 1) : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SCAN  = 3'd2,
    ALLOC = 3'd3,
    DRAIN = 3'd4
  } walker_state_e;

  walker_state_e                   state_q;
  hpdcache_set_t                   set_q;
  hpdcache_way_vector_t            dirty_q;
  hpdcache_tag_t [NWAYS-1:0]       tag_q;
  logic                            start_ready_q;
  logic                            busy_q;
  logic                            read_q;
  logic                            alloc_q;
  logic                            done_q;

  hpdcache_way_vector_t            sel_way;
  logic [WAY_W-1:0]                sel_idx;
  logic                            alloc_accept;

  // Lowest-index dirty way, as one-hot and as an index into the tag register.
  assign sel_way = hpdcache_way_vector_t'(hpdcache_prio_1hot(32'(dirty_q)));
  assign sel_idx = WAY_W'(hpdcache_1hot_to_binary(hpdcache_prio_1hot(32'(dirty_q))));

  // alloc_q tracks "dirty vector non-empty" while in ALLOC, so an accept
  // clears exactly one way and the next way shows up on the following cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      set_q         <= '0;
      dirty_q       <= '0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      read_q        <= 1'b0;
      alloc_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i && start_ready_q) begin
            set_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            read_q        <= 1'b1;
            state_q       <= READ;
          end
        end
        READ: begin
          if (dir_read_gnt_i) begin
            read_q  <= 1'b0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          dirty_q <= dir_dirty_i;
          alloc_q <= |dir_dirty_i;
          state_q <= ALLOC;
        end
        ALLOC: begin
          if (alloc_q) begin
            if (flush_alloc_ready_i) begin
              dirty_q <= dirty_q & ~sel_way;
              alloc_q <= |(dirty_q & ~sel_way);
            end
          end else if (set_q == LAST_SET) begin
            set_q   <= '0;
            state_q <= DRAIN;
          end else begin
            set_q   <= set_q + hpdcache_set_t'(1);
            read_q  <= 1'b1;
            state_q <= READ;
          end
        end
        DRAIN: begin
          if (flush_empty_i) begin
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag capture needs no reset: it is only consumed behind a non-zero dirty
  // vector, which is itself reset.
  always_ff @(posedge clk_i) begin
    if (state_q == SCAN) tag_q <= dir_tag_i;
  end

  // Request valids are masked during reset so an abort can never transfer.
  assign alloc_accept          = flush_alloc_o & flush_alloc_ready_i;
  assign start_ready_o         = start_ready_q;
  assign busy_o                = busy_q;
  assign done_o                = done_q & ~rst_i;
  assign dir_read_o            = read_q & ~rst_i;
  assign dir_read_set_o        = set_q;
  assign flush_alloc_o         = alloc_q & ~rst_i;
  assign flush_alloc_nline_o   = hpdcache_nline_t'({tag_q[sel_idx], set_q});
  assign flush_alloc_way_o     = sel_way;
  assign flush_alloc_bank_id_o = hpdcache_bank_id_t'(set_q & BANK_MASK);
  assign dir_clean_o           = alloc_accept;
  assign dir_clean_set_o       = set_q;
  assign dir_clean_way_o       = sel_way;
  assign dbg_state_o           = state_q;

endmodule

// File: doc/hpdcache_flush_walker.md
HPDCACHE_FLUSH_WALKER -- requirements
Module: hpdcache_flush_walker

Interface
REQ-001 SHALL have parameter HPDcacheCfg, default '0: cache configuration; nSets, nWays, nBanks and setWidth are taken from it.
REQ-002 SHALL have type parameters hpdcache_set_t, hpdcache_tag_t, hpdcache_nline_t, hpdcache_way_vector_t and hpdcache_bank_id_t, each defaulting to logic.
REQ-003 SHALL have clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have start_i, input, 1 bit, and start_ready_o, output, 1 bit: flush-all command handshake.
REQ-006 SHALL have busy_o, output, 1 bit (walk in progress), and done_o, output, 1 bit (single-cycle completion pulse).
REQ-007 SHALL have dir_read_o, output, 1 bit; dir_read_gnt_i, input, 1 bit; dir_read_set_o, output, set width: directory read request.
REQ-008 SHALL have dir_dirty_i, input, nWays bits, and dir_tag_i, input, nWays x tag width: directory read response.
REQ-009 SHALL have dir_clean_o, output, 1 bit; dir_clean_set_o, output, set width; dir_clean_way_o, output, one-hot nWays: dirty-bit clear.
REQ-010 SHALL have flush_alloc_o, output, 1 bit; flush_alloc_ready_i, input, 1 bit; flush_alloc_nline_o, output, nline width; flush_alloc_way_o, output, one-hot nWays; flush_alloc_bank_id_o, output, bank-id width: request to the flush controller.
REQ-011 SHALL have flush_empty_i, input, 1 bit: flush controller holds no outstanding writebacks.

Function
REQ-012 SHALL implement the states IDLE, READ, SCAN, ALLOC and DRAIN.
REQ-013 SHALL assert start_ready_o only in IDLE; start_i && start_ready_o SHALL clear the set counter to 0 and move to READ.
REQ-014 SHALL ignore start_i in every state other than IDLE.
REQ-015 In READ, SHALL assert dir_read_o with dir_read_set_o equal to the set counter; dir_read_o SHALL stay high until dir_read_gnt_i is sampled high, then the FSM SHALL move to SCAN.
REQ-016 In SCAN, SHALL latch dir_dirty_i and dir_tag_i (valid exactly one cycle after the grant) into a dirty-vector register and a tag register, then move to ALLOC.
REQ-017 In ALLOC with a non-zero dirty vector, SHALL select the lowest-index dirty way w and assert flush_alloc_o with:
  - flush_alloc_nline_o = {tag[w], set}
  - flush_alloc_way_o = onehot(w)
  - flush_alloc_bank_id_o = set[log2(nBanks)-1:0], or 0 when nBanks = 1
REQ-018 On flush_alloc_o && flush_alloc_ready_i, SHALL in the same cycle pulse dir_clean_o with set/way equal to the accepted request and clear bit w of the dirty vector; the next dirty way SHALL be presented no earlier than the following cycle.
REQ-019 In ALLOC with an empty dirty vector (including a set with no dirty ways at all), SHALL:
  - move to DRAIN if set = nSets-1, leaving the set counter at 0 (wrap);
  - otherwise increment the set counter by 1 and move to READ.
REQ-020 In DRAIN, SHALL wait for flush_empty_i = 1, then pulse done_o for one cycle and return to IDLE.
REQ-021 SHALL keep flush_alloc_o asserted with stable payload until it is accepted (no retraction).
REQ-022 SHALL assert busy_o in every state except IDLE.
REQ-023 SHALL never assert dir_read_o and flush_alloc_o in the same cycle.

Reset
REQ-024 While rst_i = 1, the FSM SHALL go to IDLE, the set counter and dirty vector SHALL clear, and all valid/pulse outputs SHALL be 0 except start_ready_o, which SHALL be 1 after reset.
REQ-025 Reset asserted mid-walk SHALL abort the walk silently: no done_o and no further allocation or clean.
REQ-026 The tag register SHALL not need a reset.

Structure
REQ-027 The walker state enumeration SHALL be local to the module; no new types SHALL be added to hpdcache_pkg.
REQ-028 Lowest-dirty-way selection SHALL reuse the existing priority-encoder/1-hot-to-binary helpers; no other sub-module is required.

Verification (nSets=4, nWays=2, nBanks=1)
REQ-029 All lines clean; start -> 4 reads (sets 0..3), zero allocations; done_o 1 cycle after flush_empty_i=1.
REQ-030 Set 2 dirty=2'b11, tags 0x10/0x11 -> allocs nline {0x10,2} way 01, then {0x11,2} way 10; one dir_clean_o pulse per accepted alloc.
REQ-031 flush_alloc_ready_i held low 5 cycles -> flush_alloc_o and its payload stable for those 5 cycles; exactly one accept.
REQ-032 dir_read_gnt_i delayed 3 cycles -> dir_read_o held 3 cycles; data sampled exactly 1 cycle after the grant.
REQ-033 flush_empty_i low for 10 cycles in DRAIN -> no done_o; start_i pulsed during the walk is ignored.
REQ-034 rst_i asserted while in ALLOC -> next cycle IDLE, start_ready_o=1, no done_o, no further allocation.
